ray_direction_gen: RTL and testbench
====================================

# ray_direction_gen

Per-frame primary-ray direction generator that sits directly upstream of the inverted-direction stage. It scans the image plane in raster order and emits one `TaggedDirection` per pixel, with the pixel-centre direction in signed Q-format fixed point and a sequential tag. Issue is gated by a credit counter sized to the downstream input FIFO, because that stage exposes no backpressure. Credits come back on the downstream in-order `valid_out`.

## Interface
- `WIDTH`, `` `WIDTH ``: bit width of each direction component (signed, two's complement).
- `Q_BITS`, `` `Q_BITS ``: fractional bits; must be ≥ 1.
- `TAG_SIZE`, `` `TAG_SIZE ``: tag field width.
- `IMG_W`, 64: pixels per row; must be even, ≥ 2.
- `IMG_H`, 48: rows per frame; must be even, ≥ 2.
- `FOCAL`, 64: focal distance in pixel units (positive integer).
- `CREDITS`, 24: maximum outstanding directions; equals downstream input FIFO depth.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  single-cycle request to begin a frame.
- `ret_valid`  in  1  connect to inverted-direction `valid_out`; each high cycle returns one credit.
- `dir_valid`  out  1  connect to inverted-direction `start`; `direction_out` valid this cycle.
- `direction_out`  out  `TaggedDirection`  tag plus x, y, z components.
- `busy`  out  1  high from frame accept until `frame_done`.
- `frame_done`  out  1  one-cycle pulse when every issued direction has returned.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: on `frame_start`, clear `px`, `py` and the tag, set `busy`, and go to ISSUE. While busy, `frame_start` is ignored and not queued.
- ISSUE: each cycle with `credit > 0`:
  - register `dir_valid=1` with the current pixel and advance `px`.
  - At `px=IMG_W-1`, wrap `px` to 0 and increment `py`.
  - After pixel (`IMG_W-1`, `IMG_H-1`), go to DRAIN.
  - With `credit == 0`, `dir_valid=0` and the counters hold.
- DRAIN: wait until `credit == CREDITS`, then pulse `frame_done`, clear `busy`, and go to IDLE. If credit is already full on DRAIN entry, pulse the next cycle.
- Credit counter (range 0..`CREDITS`, width clog2(`CREDITS`+1)):
  - issue alone: −1.
  - `ret_valid` alone: +1.
  - both in the same cycle: unchanged.
  - `ret_valid` at `CREDITS` saturates (spurious return) and never overflows.
  - The issue decision uses the registered credit value, so a same-cycle return does not unblock that cycle.
- Direction arithmetic (no multipliers; shifts and adds only), sign-extended to `WIDTH`:
  - x = (2·px + 1 − `IMG_W`) << (`Q_BITS`−1).
  - y = (`IMG_H` − 1 − 2·py) << (`Q_BITS`−1). Y points up, so row 0 is the top.
  - z = `FOCAL` << `Q_BITS`.
  - Even `IMG_W`/`IMG_H` guarantee x, y ≠ 0, so the downstream divide never sees zero.
  - Parameters must satisfy: max |x|, |y|, z fit in `WIDTH` signed. Elaboration-time assertion.
- Tag: linear pixel index modulo 2^`TAG_SIZE`. It starts at 0 each frame, increments per issued direction, and wraps silently.

## Timing
- Reset values: `dir_valid=0`, `direction_out=0`, `busy=0`, `frame_done=0`, state IDLE, `credit=CREDITS`, counters 0.
- All outputs are registered.
- Latency: `frame_start` sampled at edge k gives `busy=1` from k+1 and the first `dir_valid` (pixel 0, tag 0) in cycle k+2. The k+1 cycle is the ISSUE entry.
- Throughput: 1 direction/cycle while credits remain.
- A frame with unstalled returns completes issue in `IMG_W`·`IMG_H` consecutive `dir_valid` cycles.
- `direction_out` holds its last value when `dir_valid=0`.
- Reset mid-frame: immediate return to reset values next cycle, with no `frame_done`. The downstream stage shares `reset`, so the credits stay consistent.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0, `credit=CREDITS`, `busy=0`.
- `IMG_W=4`, `IMG_H=2`, `Q_BITS=16`, `FOCAL=64`, `ret_valid` tied to a 5-cycle-delayed `dir_valid`. Check 8 directions with tags 0..7:
  - first: x=−98304, y=32768, z=4194304.
  - fifth: x=−98304, y=−32768.
  - last: x=98304, y=−32768.
  - Then exactly one `frame_done` pulse and `busy` falls.
- `CREDITS=4`, no returns: exactly 4 `dir_valid` cycles, then the stall holds with `busy=1`. Drive one `ret_valid` and see exactly one more direction (tag 4) one cycle later.
- Simultaneous issue and `ret_valid` at `credit=1`: credit stays 1 and issue continues every cycle. A spurious `ret_valid` at full credit keeps `credit=CREDITS`.
- `TAG_SIZE=2`, 8-pixel frame: tags 0,1,2,3,0,1,2,3. `frame_start` pulsed mid-frame is ignored, with pixel order unchanged.
- Assert `reset` during ISSUE after 3 issues: next cycle all outputs are 0 and `credit=CREDITS`. A following `frame_start` restarts from pixel 0, tag 0.

Source files
------------

// File: rtl/ray_direction_gen.sv
// Raster-order primary-ray direction generator with credit-based issue.
// Emits {tag, x, y, z} per pixel centre in signed Q fixed point.
module ray_direction_gen #(
   parameter int WIDTH    = 32,
   parameter int Q_BITS   = 16,
   parameter int TAG_SIZE = 8,
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 48,
   parameter int FOCAL    = 64,
   parameter int CREDITS  = 24
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          frame_start,
   input  logic                          ret_valid,
   output logic                          dir_valid,
   output logic [TAG_SIZE+3*WIDTH-1:0]   direction_out,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int PXW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int PYW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int CW  = $clog2(CREDITS + 1);

   localparam longint LIM  = longint'(1) << (WIDTH - 1);
   localparam longint XMAX = longint'(IMG_W - 1) << (Q_BITS - 1);
   localparam longint YMAX = longint'(IMG_H - 1) << (Q_BITS - 1);
   localparam longint ZVAL = longint'(FOCAL) << Q_BITS;

   localparam logic [WIDTH-1:0] Z_DIR = WIDTH'(ZVAL);

   generate
      if (Q_BITS < 1 || IMG_W < 2 || IMG_H < 2 ||
          (IMG_W % 2) != 0 || (IMG_H % 2) != 0 ||
          FOCAL < 1 || CREDITS < 1 ||
          XMAX >= LIM || YMAX >= LIM || ZVAL >= LIM) begin : g_bad_params
         $error("ray_direction_gen: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [PXW-1:0]   px;
   logic [PYW-1:0]   py;
   logic [TAG_SIZE-1:0] tag;
   logic [CW-1:0]    credit;

   logic             issue;
   logic             last_px;
   logic             last_pix;
   logic             credit_full;
   logic             busy_nx;
   logic             done_nx;
   logic [WIDTH-1:0] x_pix;
   logic [WIDTH-1:0] y_pix;

   assign credit_full = (credit == CW'(CREDITS));
   assign last_px     = (px == PXW'(IMG_W - 1));
   assign last_pix    = last_px && (py == PYW'(IMG_H - 1));

   // 2*px+1 and 2*py are formed by concatenation, so no multiplier
   assign x_pix = (WIDTH'({px, 1'b1}) - WIDTH'(IMG_W)) << (Q_BITS - 1);
   assign y_pix = (WIDTH'(IMG_H - 1) - WIDTH'({py, 1'b0})) << (Q_BITS - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (frame_start) state_nx = ISSUE;
         ISSUE:   if (issue && last_pix) state_nx = DRAIN;
         DRAIN:   if (credit_full) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Issue looks only at the registered credit; a same-cycle return waits
   always_comb begin
      issue   = 1'b0;
      done_nx = 1'b0;
      busy_nx = 1'b0;
      unique case (state)
         IDLE: busy_nx = frame_start;
         ISSUE: begin
            issue   = (credit != '0);
            busy_nx = 1'b1;
         end
         DRAIN: begin
            done_nx = credit_full;
            busy_nx = !credit_full;
         end
         default: busy_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         credit        <= CW'(CREDITS);
         px            <= '0;
         py            <= '0;
         tag           <= '0;
         dir_valid     <= 1'b0;
         direction_out <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         dir_valid  <= issue;
         busy       <= busy_nx;
         frame_done <= done_nx;

         if (issue && !ret_valid) begin
            credit <= credit - CW'(1);
         end else if (!issue && ret_valid && !credit_full) begin
            credit <= credit + CW'(1);
         end

         if (state == IDLE && frame_start) begin
            px  <= '0;
            py  <= '0;
            tag <= '0;
         end else if (issue) begin
            direction_out <= {tag, x_pix, y_pix, Z_DIR};
            tag           <= tag + TAG_SIZE'(1);
            if (last_px) begin
               px <= '0;
               py <= py + PYW'(1);
            end else begin
               px <= px + PXW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ray_direction_gen.sv
// Scoreboard bench for ray_direction_gen on a 4x2 image, 4 credits.
// Expected directions come from a plain-arithmetic pixel model.
module tb_ray_direction_gen;

   localparam int WIDTH    = 32;
   localparam int Q_BITS   = 16;
   localparam int TAG_SIZE = 2;
   localparam int IMG_W    = 4;
   localparam int IMG_H    = 2;
   localparam int FOCAL    = 64;
   localparam int CREDITS  = 4;
   localparam int OW       = TAG_SIZE + 3 * WIDTH;
   localparam int NPIX     = IMG_W * IMG_H;

   logic          clk;
   logic          reset;
   logic          frame_start;
   logic          ret_valid;
   logic          dir_valid;
   logic [OW-1:0] direction_out;
   logic          busy;
   logic          frame_done;

   logic          auto_ret;
   logic          ret_manual;
   logic [5:0]    hist;

   int checks;
   int errors;
   int dv_count;
   int fd_count;

   logic [OW-1:0] exp_q[$];
   logic [OW-1:0] got[$];

   ray_direction_gen #(
      .WIDTH(WIDTH), .Q_BITS(Q_BITS), .TAG_SIZE(TAG_SIZE),
      .IMG_W(IMG_W), .IMG_H(IMG_H), .FOCAL(FOCAL), .CREDITS(CREDITS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .frame_start(frame_start),
      .ret_valid(ret_valid),
      .dir_valid(dir_valid),
      .direction_out(direction_out),
      .busy(busy),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream stand-in: each dir_valid comes back 5 cycles later
   assign ret_valid = auto_ret ? hist[5] : ret_manual;

   initial begin
      hist = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) hist = '0;
         else hist = {hist[4:0], dir_valid};
      end
   end

   function automatic logic [OW-1:0] model(int i);
      int px, py, x, y, z, t;
      px = i % IMG_W;
      py = i / IMG_W;
      x  = (2 * px + 1 - IMG_W) * (1 << (Q_BITS - 1));
      y  = (IMG_H - 1 - 2 * py) * (1 << (Q_BITS - 1));
      z  = FOCAL * (1 << Q_BITS);
      t  = i % (1 << TAG_SIZE);
      return {TAG_SIZE'(t), WIDTH'(x), WIDTH'(y), WIDTH'(z)};
   endfunction

   function automatic int f_tag(logic [OW-1:0] d);
      return int'(d[3*WIDTH +: TAG_SIZE]);
   endfunction
   function automatic int f_x(logic [OW-1:0] d);
      return int'(signed'(d[2*WIDTH +: WIDTH]));
   endfunction
   function automatic int f_y(logic [OW-1:0] d);
      return int'(signed'(d[WIDTH +: WIDTH]));
   endfunction
   function automatic int f_z(logic [OW-1:0] d);
      return int'(signed'(d[0 +: WIDTH]));
   endfunction

   always @(negedge clk) begin
      if (dir_valid) begin
         dv_count++;
         got.push_back(direction_out);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dir got=%h required=none", direction_out);
         end else begin
            logic [OW-1:0] e;
            e = exp_q.pop_front();
            if (direction_out !== e) begin
               errors++;
               $display("FAIL dir_scoreboard got=%h required=%h", direction_out, e);
            end
         end
      end
      if (frame_done) fd_count++;
   end

   task automatic chk(string name, int g, int e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, g, e);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_counts();
      dv_count = 0;
      fd_count = 0;
      got.delete();
   endtask

   task automatic start_frame(bit accept);
      if (accept) for (int i = 0; i < NPIX; i++) exp_q.push_back(model(i));
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic wait_dv(int n, int budget);
      int k;
      k = 0;
      while (dv_count < n && k < budget) begin
         step();
         k++;
      end
      if (dv_count < n) chk("wait_dv_timeout", dv_count, n);
   endtask

   task automatic wait_done(int budget);
      int k;
      k = 0;
      while (fd_count < 1 && k < budget) begin
         step();
         k++;
      end
      if (fd_count < 1) chk("wait_done_timeout", fd_count, 1);
      else chk("busy_at_done", int'(busy), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      exp_q.delete();
      reset = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      dv_count    = 0;
      fd_count    = 0;
      reset       = 1'b1;
      frame_start = 1'b0;
      auto_ret    = 1'b0;
      ret_manual  = 1'b0;

      // reset then idle
      repeat (3) step();
      reset = 1'b0;
      repeat (10) step();
      chk("rst_dir_valid", int'(dir_valid), 0);
      chk("rst_direction", int'(direction_out != '0), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_credit", int'(dut.credit), CREDITS);
      chk("rst_no_dirs", dv_count, 0);

      // full frame with delayed returns, latency and spot values
      auto_ret = 1'b1;
      clear_counts();
      for (int i = 0; i < NPIX; i++) exp_q.push_back(model(i));
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("lat_busy_k1", int'(busy), 1);
      chk("lat_dv_k1", int'(dir_valid), 0);
      step();
      chk("lat_dv_k2", int'(dir_valid), 1);
      chk("lat_tag_k2", f_tag(direction_out), 0);
      wait_done(200);
      repeat (5) step();
      chk("frame_dirs", dv_count, NPIX);
      chk("frame_done_once", fd_count, 1);
      chk("frame_busy_low", int'(busy), 0);
      chk("frame_queue_empty", exp_q.size(), 0);
      if (got.size() == NPIX) begin
         chk("first_x", f_x(got[0]), -98304);
         chk("first_y", f_y(got[0]), 32768);
         chk("first_z", f_z(got[0]), 4194304);
         chk("fifth_x", f_x(got[4]), -98304);
         chk("fifth_y", f_y(got[4]), -32768);
         chk("last_x", f_x(got[7]), 98304);
         chk("last_y", f_y(got[7]), -32768);
      end else begin
         chk("frame_capture_size", got.size(), NPIX);
      end

      // no returns: credit stall, then one return releases one direction
      auto_ret = 1'b0;
      clear_counts();
      start_frame(1'b1);
      repeat (20) step();
      chk("stall_dirs", dv_count, CREDITS);
      chk("stall_busy", int'(busy), 1);
      chk("stall_credit", int'(dut.credit), 0);
      ret_manual = 1'b1;
      step();
      ret_manual = 1'b0;
      step();
      chk("release_dv", int'(dir_valid), 1);
      chk("release_tag", f_tag(direction_out), CREDITS % (1 << TAG_SIZE));
      repeat (10) step();
      chk("release_dirs", dv_count, CREDITS + 1);
      do_reset();
      step();

      // simultaneous issue and return at credit 1, spurious return when full
      clear_counts();
      start_frame(1'b1);
      wait_dv(3, 20);
      chk("sim_credit_pre", int'(dut.credit), 1);
      ret_manual = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("sim_dv", int'(dir_valid), 1);
         chk("sim_credit", int'(dut.credit), 1);
      end
      wait_done(40);
      chk("sim_dirs", dv_count, NPIX);
      repeat (3) step();
      chk("spurious_credit", int'(dut.credit), CREDITS);
      ret_manual = 1'b0;
      step();

      // tag wrap and ignored mid-frame frame_start
      auto_ret = 1'b1;
      clear_counts();
      start_frame(1'b1);
      wait_dv(3, 20);
      start_frame(1'b0);
      wait_done(200);
      repeat (6) step();
      chk("ign_dirs", dv_count, NPIX);
      chk("ign_queue_empty", exp_q.size(), 0);
      chk("ign_busy", int'(busy), 0);
      for (int i = 0; i < got.size(); i++) begin
         chk($sformatf("wrap_tag%0d", i), f_tag(got[i]), i % 4);
      end

      // reset in the middle of issue
      clear_counts();
      start_frame(1'b1);
      wait_dv(3, 20);
      do_reset();
      chk("mrst_dir_valid", int'(dir_valid), 0);
      chk("mrst_direction", int'(direction_out != '0), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_frame_done", int'(frame_done), 0);
      chk("mrst_credit", int'(dut.credit), CREDITS);
      repeat (8) step();
      chk("mrst_no_done", fd_count, 0);
      clear_counts();
      start_frame(1'b1);
      wait_done(200);
      chk("restart_dirs", dv_count, NPIX);
      if (got.size() > 0) begin
         chk("restart_tag0", f_tag(got[0]), 0);
         chk("restart_x0", f_x(got[0]), -98304);
         chk("restart_y0", f_y(got[0]), 32768);
      end else begin
         chk("restart_capture", got.size(), NPIX);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
